// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetches one 16-bit instruction word per instruction period and holds it
//   steady for four execution phases (P2..P5). The program counter advances
//   in P5. It either increments or loads a branch target. A HLT encoding
//   (op[15:14]=2'b11 and op[7:4]=4'b1111) parks the unit in HALT until the
//   restart input is asserted.
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   imem_req    out  1   instruction-memory read request (FETCH only)
//   imem_addr   out  16  read address, always equal to pc
//   imem_rdata  in   16  instruction word, valid with imem_ack
//   imem_ack    in   1   memory response, sampled only while imem_req=1
//   br_taken    in   1   branch-taken indication, sampled in P5 only
//   br_target   in   16  branch destination address
//   restart     in   1   leave HALT, sampled in HALT only
//   op          out  16  current instruction word
//   op_valid    out  1   op is stable and executable (P2..P5)
//   phase       out  5   one-hot {P5,P4,P3,P2,FETCH}, all zero in HALT
//   pc          out  16  program counter
//   halted      out  1   high in HALT
//   stall_cnt   out  16  saturating count of un-acked FETCH cycles
//                        (only when IFU_STALL_COUNT_EN is defined)
//
// Configuration macro:
//   IFU_STALL_COUNT_EN  adds the stall_cnt output and its counter.
// ---------------------------------------------------------------------------
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        restart,
  output logic [15:0] op,
  output logic        op_valid,
  output logic [4:0]  phase,
  output logic [15:0] pc,
  output logic        halted
`ifdef IFU_STALL_COUNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_P2    = 3'd1,
    S_P3    = 3'd2,
    S_P4    = 3'd3,
    S_P5    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t state, state_next;

  logic fetch_done;
  logic halt_word;

  // A fetch completes only when a request is outstanding, so an ack that
  // arrives in any other state is ignored by construction.
  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign halt_word  = (op[15:14] == 2'b11) && (op[7:4] == 4'b1111);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (imem_ack) state_next = S_P2;
      S_P2:    state_next = S_P3;
      S_P3:    state_next = S_P4;
      S_P4:    state_next = S_P5;
      S_P5:    state_next = halt_word ? S_HALT : S_FETCH;
      S_HALT:  if (restart) state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore outputs, depend on state only)
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    op_valid = 1'b0;
    halted   = 1'b0;
    phase    = 5'b00000;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        phase    = 5'b00001;
      end
      S_P2: begin
        op_valid = 1'b1;
        phase    = 5'b00010;
      end
      S_P3: begin
        op_valid = 1'b1;
        phase    = 5'b00100;
      end
      S_P4: begin
        op_valid = 1'b1;
        phase    = 5'b01000;
      end
      S_P5: begin
        op_valid = 1'b1;
        phase    = 5'b10000;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc;

  // -------------------------------------------------------------------------
  // Instruction and program-counter registers
  // -------------------------------------------------------------------------
  // NOTE: op is a plain data register but still gets a reset value, because
  // downstream decoders see it directly and must start from a known word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= 16'h0000;
      pc <= 16'h0000;
    end else begin
      if (fetch_done) begin
        op <= imem_rdata;
      end
      // The pc update happens even for a HLT word, so a branching HLT
      // resumes at its target after restart.
      if (state == S_P5) begin
        pc <= br_taken ? br_target : pc + 16'd1;
      end
    end
  end

`ifdef IFU_STALL_COUNT_EN
  // -------------------------------------------------------------------------
  // Stall counter: FETCH cycles without an ack, saturating at 0xFFFF.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if ((state == S_FETCH) && !imem_ack && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Self-checking bench for instruction_fetch_unit. A table of instruction
// records gives the word returned by memory, the wait states, where to pulse
// br_taken, and the expected pc and halt outcome. Fetched words go into a
// scoreboard queue when the ack is driven. They are popped and compared when
// op_valid appears. Hand-written sequences cover asynchronous reset in P3
// and during an outstanding fetch.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        restart = 1'b0;
  logic [15:0] op;
  logic        op_valid;
  logic [4:0]  phase;
  logic [15:0] pc;
  logic        halted;
`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_cnt;
`endif

  instruction_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .restart    (restart),
    .op         (op),
    .op_valid   (op_valid),
    .phase      (phase),
    .pc         (pc),
    .halted     (halted)
`ifdef IFU_STALL_COUNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;       // instruction word returned by memory
    int          ws;         // FETCH cycles with imem_ack=0 before the ack
    int          br_phase;   // phase (2..5) in which br_taken pulses, 0 = none
    logic [15:0] br_target;
    logic [15:0] exp_pc;     // pc expected after P5
    logic        exp_halt;   // HALT expected after P5
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_addr = 16'h0000;
  logic [15:0] exp_op = 16'h0000;
  int          exp_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},       32'(pc), 0);
    check({tag, "_addr"},     32'(imem_addr), 0);
    check({tag, "_op"},       32'(op), 0);
    check({tag, "_op_valid"}, 32'(op_valid), 0);
    check({tag, "_halted"},   32'(halted), 0);
    check({tag, "_phase"},    32'(phase), 1);
    check({tag, "_req"},      32'(imem_req), 1);
`ifdef IFU_STALL_COUNT_EN
    check({tag, "_stall"},    32'(stall_cnt), 0);
`endif
  endtask

  // Runs one instruction period starting at the negedge of a FETCH cycle.
  task automatic run_instr(input vec_t v);
    logic [15:0] w;
    check("fetch_req",   32'(imem_req), 1);
    check("fetch_addr",  32'(imem_addr), 32'(exp_addr));
    check("fetch_phase", 32'(phase), 1);
    check("fetch_valid", 32'(op_valid), 0);
    for (int k = 0; k < v.ws; k++) begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      @(negedge clk);
      if (exp_stall < 65535) exp_stall++;
      check("wait_req",   32'(imem_req), 1);
      check("wait_addr",  32'(imem_addr), 32'(exp_addr));
      check("wait_valid", 32'(op_valid), 0);
      check("wait_op",    32'(op), 32'(exp_op));
    end
`ifdef IFU_STALL_COUNT_EN
    check("stall_cnt", 32'(stall_cnt), exp_stall);
`endif
    imem_ack   = 1'b1;
    imem_rdata = v.word;
    sb.push_back(v.word);
    exp_op = v.word;
    @(negedge clk);
    for (int p = 2; p <= 5; p++) begin
      // Stray ack, restart and data must all be ignored here.
      imem_ack   = 1'b1;
      imem_rdata = 16'hDEAD;
      restart    = 1'b1;
      br_taken   = (p == v.br_phase);
      br_target  = v.br_target;
      check("exec_phase", 32'(phase), 1 << (p - 1));
      check("exec_valid", 32'(op_valid), 1);
      check("exec_req",   32'(imem_req), 0);
      if (p == 2) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: no expected word queued when op_valid rose");
        end else begin
          w = sb.pop_front();
          check("op_word", 32'(op), 32'(w));
        end
      end else begin
        check("op_hold", 32'(op), 32'(exp_op));
      end
      @(negedge clk);
    end
    br_taken = 1'b0;
    restart  = 1'b0;
    imem_ack = 1'b0;
    check("next_pc",  32'(pc), 32'(v.exp_pc));
    check("halted",   32'(halted), 32'(v.exp_halt));
    if (v.exp_halt) begin
      for (int k = 0; k < 2; k++) begin
        imem_ack = 1'b1;
        check("halt_req",   32'(imem_req), 0);
        check("halt_phase", 32'(phase), 0);
        check("halt_valid", 32'(op_valid), 0);
        check("halt_op",    32'(op), 32'(exp_op));
        @(negedge clk);
        check("halt_stay", 32'(halted), 1);
      end
      imem_ack = 1'b0;
      restart  = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_fetch", 32'(phase), 1);
      check("restart_pc",    32'(pc), 32'(v.exp_pc));
    end
    exp_addr = v.exp_pc;
  endtask

  initial begin
    //           word      ws br  target    exp_pc    halt
    vecs[0] = '{16'h1234, 0, 0, 16'h0000, 16'h0001, 1'b0};
    vecs[1] = '{16'h5678, 3, 3, 16'h0200, 16'h0002, 1'b0};
    vecs[2] = '{16'h0001, 1, 5, 16'h0040, 16'h0040, 1'b0};
    vecs[3] = '{16'h1111, 0, 5, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[4] = '{16'hC0F0, 2, 0, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{16'hC0F0, 0, 5, 16'h0100, 16'h0100, 1'b1};
    vecs[6] = '{16'hC00F, 0, 0, 16'h0000, 16'h0101, 1'b0};
    vecs[7] = '{16'h3FF0, 1, 4, 16'h0000, 16'h0102, 1'b0};

    // Reset values while rst_n is held low from time zero.
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_instr(vecs[i]);

    // Reset asserted in P3 between clock edges.
    imem_ack   = 1'b1;
    imem_rdata = 16'h4444;
    sb.push_back(16'h4444);
    exp_op = 16'h4444;
    @(negedge clk);
    imem_ack = 1'b0;
    check("p2_word", 32'(op), 32'(sb.pop_front()));
    @(negedge clk);
    check("p3_phase", 32'(phase), 4);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_p3");
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 16'h0000;
    exp_op = 16'h0000;
    exp_stall = 0;

    // Move pc to 1, then reset during an outstanding fetch.
    run_instr(vecs[0]);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pending_req",  32'(imem_req), 1);
    check("pending_addr", 32'(imem_addr), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_fetch");
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 16'h0000;
    exp_op = 16'h0000;
    exp_stall = 0;
    run_instr(vecs[0]);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows (clock and reset first).
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  16  read address; equals pc.
- imem_rdata  input  16  instruction word; valid when imem_ack=1.
- imem_ack  input  1  memory response; sampled only while imem_req=1.
- br_taken  input  1  branch-taken indication from execute logic.
- br_target  input  16  branch destination address.
- restart  input  1  leave HALT.
- op  output  16  current instruction word to the decoders and the data-selector controller.
- op_valid  output  1  op is stable and executable.
- phase  output  5  one-hot phase: [0]=FETCH, [1]=P2, [2]=P3, [3]=P4, [4]=P5; all zero in HALT.
- pc  output  16  program counter.
- halted  output  1  high in HALT.

Function
REQ-002 The block SHALL implement the states FETCH, P2, P3, P4, P5 and HALT.
REQ-003 FETCH: imem_req=1 and imem_addr=pc; if imem_ack=0, remain in FETCH; if imem_ack=1, latch op<=imem_rdata and go to P2 on that edge.
REQ-004 Fetch latency: op updates on the first rising edge where FETCH and imem_ack=1 are both true, and op_valid rises in the same cycle.
REQ-005 imem_req SHALL be 0 in every state other than FETCH; imem_ack SHALL be ignored when imem_req=0.
REQ-006 P2->P3->P4->P5 SHALL each advance unconditionally after one cycle.
REQ-007 op SHALL be held constant from P2 through P5 and in HALT; in FETCH op retains the previous word until the ack.
REQ-008 op_valid SHALL be 1 in P2..P5 and 0 in FETCH and HALT.
REQ-009 In P5: if br_taken=1, pc<=br_target; else pc<=pc+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-010 br_taken SHALL be ignored in every state except P5.
REQ-011 Halt detection: when op[15:14]=2'b11 and op[7:4]=4'b1111, P5 goes to HALT; otherwise P5 goes to FETCH. pc is still updated per REQ-009.
REQ-012 HALT: halted=1 and no memory request; restart=1 goes to FETCH with pc unchanged.
REQ-013 restart SHALL be ignored outside HALT.
REQ-014 A HLT word with br_taken=1 in P5 SHALL load br_target into pc and still enter HALT.

Reset
REQ-015 With rst_n=0, the block SHALL immediately (asynchronously) go to state FETCH and set pc=0x0000, op=0x0000, op_valid=0, halted=0, phase=5'b00001 and imem_req=1.
REQ-016 Reset asserted mid-operation (any state, including an outstanding FETCH) SHALL abort it; the first request after release is to address 0x0000.

Configuration
REQ-017 Macro IFU_STALL_COUNT_EN: when defined, the block SHALL add output stall_cnt (16 bits), reset to 0, which increments on every FETCH cycle with imem_ack=0 and saturates at 0xFFFF.
REQ-018 When IFU_STALL_COUNT_EN is undefined, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 Sequence at zero wait states: reset release, imem_ack=1 every FETCH, mem[0]=0x1234, mem[1]=0x5678 -> op=0x1234 for 4 cycles (P2..P5), then FETCH at addr 0x0001, giving a 5-cycle instruction period.
REQ-020 Wait states: imem_ack held 0 for 3 FETCH cycles -> imem_req stays 1 and op_valid stays 0; with the macro, stall_cnt=3.
REQ-021 Branch: br_taken=1 and br_target=0x0040 in P5 -> next imem_addr=0x0040; br_taken=1 pulsed in P3 -> no effect, pc+1.
REQ-022 Wrap and halt: pc=0xFFFF, word 0xC0F0 -> pc=0x0000, halted=1, imem_req=0; restart=1 -> FETCH at 0x0000.
REQ-023 Reset mid-P3 -> outputs take their REQ-015 values asynchronously; after release, the first fetch is at 0x0000.
